// File: rtl/bandai_mapper_pkg.sv
// rtl/bandai_mapper_pkg.sv - shared types, default constants and helpers for the bandai mapper
package bandai_mapper_pkg;

  // Unlock sequence states
  typedef enum logic [1:0] {
    WAIT_K0 = 2'd0,
    WAIT_K1 = 2'd1,
    STREAM  = 2'd2,
    OPEN    = 2'd3
  } unlock_state_e;

  localparam logic [7:0]  DEF_KEY0      = 8'h5A;
  localparam logic [7:0]  DEF_KEY1      = 8'hA5;
  localparam logic [7:0]  DEF_BANK_BASE = 8'hC0;
  // 18-bit stream pattern 18'h051400; bit 18 of the literal lies outside the field
  localparam logic [31:0] DEF_STREAM_PAT = 32'h0001_1400;

  // Ceiling log2 for elaboration-time width calculation
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bandai_unlock_seq.sv
// rtl/bandai_unlock_seq.sv - address-keyed unlock FSM with serial pattern output
module bandai_unlock_seq
  import bandai_mapper_pkg::*;
#(
  parameter int                ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] KEY0       = ADDR_W'(DEF_KEY0),
  parameter logic [ADDR_W-1:0] KEY1       = ADDR_W'(DEF_KEY1),
  parameter int                STREAM_LEN = 18,
  parameter logic [31:0]       STREAM_PAT = DEF_STREAM_PAT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] ADDR,
  output logic              SO,
  output logic              LOCKED
);

  localparam logic [5:0] STREAM_LEN_C = 6'(STREAM_LEN);

  unlock_state_e state_q, state_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [4:0]    pat_idx;

  // cnt counts down from STREAM_LEN, so the first stream cycle reads bit 0
  assign pat_idx = 5'(STREAM_LEN_C - cnt_q);

  // Next-state, bit counter and SO/LOCKED decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    SO      = 1'b1;
    LOCKED  = 1'b1;
    case (state_q)
      WAIT_K0: begin
        if (ADDR == KEY0) begin
          state_d = WAIT_K1;
        end
      end
      WAIT_K1: begin
        if (ADDR == KEY1) begin
          state_d = STREAM;
          cnt_d   = STREAM_LEN_C;
        end
      end
      STREAM: begin
        LOCKED = 1'b0;
        SO     = STREAM_PAT[pat_idx];
        cnt_d  = cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          state_d = OPEN;
        end
      end
      OPEN: begin
        LOCKED = 1'b0;
      end
      default: begin
        state_d = WAIT_K0;
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= WAIT_K0;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/bandai_mapper_gen2.sv
// rtl/bandai_mapper_gen2.sv - WonderSwan bank mapper top; MAPPER_UNLOCK_EN enables the unlock sequence
module bandai_mapper_gen2
  import bandai_mapper_pkg::*;
#(
  parameter int                NUM_BANKS  = 4,
  parameter int                ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] BANK_BASE  = ADDR_W'(DEF_BANK_BASE),
`ifdef MAPPER_UNLOCK_EN
  parameter logic [ADDR_W-1:0] KEY0       = ADDR_W'(DEF_KEY0),
  parameter logic [ADDR_W-1:0] KEY1       = ADDR_W'(DEF_KEY1),
  parameter int                STREAM_LEN = 18,
  parameter logic [31:0]       STREAM_PAT = DEF_STREAM_PAT,
`endif
  parameter logic [7:0]        BANK_RST   = 8'hFF
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   CEn,
  input  logic                   SSn,
  input  logic                   WEn,
  input  logic                   OEn,
  input  logic [ADDR_W-1:0]      ADDR,
  input  logic [7:0]             DQ_I,
  output logic [7:0]             DQ_O,
  output logic                   DQ_OE,
  output logic                   SO,
  output logic                   LOCKED,
  output logic [NUM_BANKS*8-1:0] BANK_Q
);

  localparam int IDX_W = clog2(NUM_BANKS);

  logic locked;

`ifdef MAPPER_UNLOCK_EN
  bandai_unlock_seq #(
    .ADDR_W     (ADDR_W),
    .KEY0       (KEY0),
    .KEY1       (KEY1),
    .STREAM_LEN (STREAM_LEN),
    .STREAM_PAT (STREAM_PAT)
  ) u_unlock_seq (
    .CLK    (CLK),
    .RST    (RST),
    .ADDR   (ADDR),
    .SO     (SO),
    .LOCKED (locked)
  );
`else
  assign locked = 1'b0;
  assign SO     = 1'b1;
`endif

  assign LOCKED = locked;

  // Window decode; one extra bit keeps BANK_BASE+NUM_BANKS from wrapping
  logic              in_win;
  logic              sel;
  logic [IDX_W-1:0]  rd_idx;
  logic [ADDR_W:0]   addr_ext;
  logic [ADDR_W:0]   base_ext;
  logic [ADDR_W:0]   limit_ext;

  assign addr_ext  = {1'b0, ADDR};
  assign base_ext  = {1'b0, BANK_BASE};
  assign limit_ext = base_ext + (ADDR_W + 1)'(NUM_BANKS);
  assign in_win    = (addr_ext >= base_ext) && (addr_ext < limit_ext);
  assign sel       = (~CEn | ~SSn) & in_win;
  assign rd_idx    = ADDR[IDX_W-1:0];

  logic [NUM_BANKS*8-1:0] bank_q, bank_d;

  // Combinational read path
  assign DQ_OE = ~locked & sel & ~OEn & WEn;
  assign DQ_O  = DQ_OE ? bank_q[rd_idx*8 +: 8] : 8'h00;

  // Write capture state, sampled every cycle the write strobe is low
  logic [IDX_W-1:0] cap_idx_q, cap_idx_d;
  logic [7:0]       cap_data_q, cap_data_d;
  logic             cap_sel_q, cap_sel_d;
  logic             cap_oen_q, cap_oen_d;
  logic             we_low_q, we_low_d;
  logic             commit;

  // A commit fires once, in the first cycle WEn is high after a low phase
  assign commit = we_low_q & WEn & cap_sel_q & cap_oen_q & ~locked;

  // Capture and bank-update next-state logic
  always_comb begin
    cap_idx_d  = cap_idx_q;
    cap_data_d = cap_data_q;
    cap_sel_d  = cap_sel_q;
    cap_oen_d  = cap_oen_q;
    we_low_d   = ~WEn;
    bank_d     = bank_q;
    if (!WEn) begin
      cap_idx_d  = rd_idx;
      cap_data_d = DQ_I;
      cap_sel_d  = sel;
      cap_oen_d  = OEn;
    end
    if (commit) begin
      bank_d[cap_idx_q*8 +: 8] = cap_data_q;
    end
  end

  // Capture and bank registers; reset wins over a same-edge commit
  always_ff @(posedge CLK) begin
    if (RST) begin
      cap_idx_q  <= '0;
      cap_data_q <= 8'h00;
      cap_sel_q  <= 1'b0;
      cap_oen_q  <= 1'b0;
      we_low_q   <= 1'b0;
      bank_q     <= {NUM_BANKS{BANK_RST}};
    end else begin
      cap_idx_q  <= cap_idx_d;
      cap_data_q <= cap_data_d;
      cap_sel_q  <= cap_sel_d;
      cap_oen_q  <= cap_oen_d;
      we_low_q   <= we_low_d;
      bank_q     <= bank_d;
    end
  end

  assign BANK_Q = bank_q;

endmodule
